// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the sigma helper functions
// used by the block controller and its single-round datapath.
package sha256_pkg;

    localparam int ROUNDS = 64;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    // Element 0 is the most significant word, so a hash_t is H0..H7 with H0 in [255:224].
    typedef logic [0:7][WORD_W-1:0] hash_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:ROUNDS-1][WORD_W-1:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t ror(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Message-schedule sigmas.
    function automatic word_t sigma0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Compression-function sigmas.
    function automatic word_t bsig0(input word_t x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational.
// State vector order is a..h with a in element 0.
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t state_i,
    input  word_t k_i,
    input  word_t w_i,
    output hash_t state_o
);

    word_t a, b, c, d, e, f, g, h;
    word_t ch, maj, t1, t2;

    always_comb begin
        {a, b, c, d, e, f, g, h} = state_i;
        ch  = (e & f) ^ (~e & g);
        maj = (a & b) ^ (a & c) ^ (b & c);
        t1  = h + bsig1(e) + ch + k_i + w_i;
        t2  = bsig0(a) + maj;
        state_o = {t1 + t2, a, b, c, d + t1, e, f, g};
    end

endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 single-block controller: loads 16 message words, runs 64 rounds
// one per cycle, folds the result into the chaining value and presents it.
module sha256_block_ctrl
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         first_block,
    output logic         busy,
    input  logic         word_valid,
    output logic         word_ready,
    input  logic [31:0]  word_data,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest
);

    state_t state_q, state_d;
    hash_t  h_q, h_d;
    hash_t  work_q, work_d;
    // Schedule window; element 0 is the head, i.e. W[t] during round t.
    logic [15:0][31:0] win_q, win_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [5:0] rcnt_q, rcnt_d;

    hash_t round_out;
    word_t w_next;

    sha256_round u_round (
        .state_i (work_q),
        .k_i     (K[rcnt_q]),
        .w_i     (win_q[0]),
        .state_o (round_out)
    );

    // W[t+16] from the current window, fed into the tail as the head retires.
    assign w_next = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        work_d  = work_q;
        win_d   = win_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    wcnt_d  = '0;
                    if (first_block) begin
                        h_d    = IV;
                        work_d = IV;
                    end else begin
                        work_d = h_q;
                    end
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    win_d  = {word_data, win_q[15:1]};
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == 4'd15) begin
                        state_d = S_ROUND;
                        rcnt_d  = '0;
                    end
                end
            end
            S_ROUND: begin
                work_d = round_out;
                win_d  = {w_next, win_q[15:1]};
                rcnt_d = rcnt_q + 6'd1;
                if (rcnt_q == 6'(ROUNDS - 1)) state_d = S_FINAL;
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + work_q[i];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (digest_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            h_q     <= IV;
            work_q  <= '0;
            win_q   <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            work_q  <= work_d;
            win_q   <= win_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign word_ready   = (state_q == S_LOAD);
    assign digest_valid = (state_q == S_DONE);
    assign digest       = h_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl with a digest scoreboard.
module tb_sha256_block_ctrl;

    logic         clk = 1'b0;
    logic         rst, start, first_block, word_valid, digest_ready;
    logic         busy, word_ready, digest_valid;
    logic [31:0]  word_data;
    logic [255:0] digest;

    sha256_block_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .first_block  (first_block),
        .busy         (busy),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .digest       (digest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef logic [31:0] blk_t [16];
    typedef struct {
        bit           chk;
        logic [255:0] dg;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [255:0] IV_DG  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMP_DG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    blk_t abc_b, emp_b, two1_b, two2_b;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit fb);
        start = 1'b1;
        first_block = fb;
        step();
        start = 1'b0;
        chk("start_load", word_ready, 1);
    endtask

    task automatic send_block(input blk_t w, input bit gaps, output int t_hs);
        t_hs = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                word_valid = 1'b0;
                word_data  = $urandom;
                repeat ($urandom_range(0, 3)) step();
            end
            word_valid = 1'b1;
            word_data  = w[i];
            t_hs = cyc;
            if (i == 0 || i == 15) chk("word_ready", word_ready, 1);
            step();
        end
        word_valid = 1'b0;
        word_data  = $urandom;
    endtask

    task automatic wait_digest(input int t_hs, input int hold, input bit start_in_hs);
        exp_t e;
        int   n = 0;
        while (!digest_valid && n < 200) begin
            step();
            n++;
        end
        chk("dv_timeout", digest_valid, 1);
        chk("latency", 256'(cyc - t_hs), 66);
        if (sb.size() == 0) begin
            chk("sb_empty", 256'(sb.size()), 1);
            e.chk = 1'b0;
            e.dg  = '0;
        end else begin
            e = sb.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            step();
            chk("hold_valid", digest_valid, 1);
            if (e.chk) chk("hold_stable", digest, e.dg);
        end
        start = 1'b0;
        if (e.chk) chk("digest", digest, e.dg);
        digest_ready = 1'b1;
        start = start_in_hs;
        step();
        digest_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_no_load", word_ready, 0);
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; first_block = 1'b0; word_valid = 1'b0;
        word_data = '0; digest_ready = 1'b0;

        abc_b = '{default: 32'h0};
        abc_b[0] = 32'h61626380; abc_b[15] = 32'h00000018;
        emp_b = '{default: 32'h0};
        emp_b[0] = 32'h80000000;
        two1_b = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two2_b = '{default: 32'h0};
        two2_b[15] = 32'h000001c0;

        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_word_ready", word_ready, 0);
        chk("rst_digest_valid", digest_valid, 0);
        chk("rst_digest", digest, IV_DG);
        rst = 1'b0;

        // Words offered in IDLE must not be consumed.
        word_valid = 1'b1; word_data = 32'hdeadbeef;
        repeat (3) step();
        chk("idle_word_ready", word_ready, 0);
        word_valid = 1'b0;

        // "abc"
        do_start(1'b1);
        sb.push_back('{1'b1, ABC_DG});
        send_block(abc_b, 1'b0, t);
        wait_digest(t, 0, 1'b0);

        // Empty message
        do_start(1'b1);
        sb.push_back('{1'b1, EMP_DG});
        send_block(emp_b, 1'b0, t);
        wait_digest(t, 0, 1'b0);

        // Two-block message; only the final digest is checked.
        do_start(1'b1);
        sb.push_back('{1'b0, 256'h0});
        send_block(two1_b, 1'b0, t);
        wait_digest(t, 0, 1'b0);
        do_start(1'b0);
        sb.push_back('{1'b1, TWO_DG});
        send_block(two2_b, 1'b0, t);
        wait_digest(t, 0, 1'b0);

        // "abc" with input gaps, start pulses in ROUND and DONE, stalled consumer.
        do_start(1'b1);
        sb.push_back('{1'b1, ABC_DG});
        send_block(abc_b, 1'b1, t);
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        chk("round_busy", busy, 1);
        chk("round_no_load", word_ready, 0);
        wait_digest(t, 10, 1'b0);

        // Abort around round 30; nothing is expected from this block.
        do_start(1'b1);
        send_block(abc_b, 1'b0, t);
        repeat (30) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_word_ready", word_ready, 0);
        chk("abort_digest_valid", digest_valid, 0);
        chk("abort_digest", digest, IV_DG);
        do_start(1'b1);
        sb.push_back('{1'b1, ABC_DG});
        send_block(abc_b, 1'b0, t);
        wait_digest(t, 0, 1'b0);

        // Back-to-back: start held through the handshake cycle and the next.
        do_start(1'b1);
        sb.push_back('{1'b1, ABC_DG});
        send_block(abc_b, 1'b0, t);
        first_block = 1'b1;
        wait_digest(t, 0, 1'b1);
        step();
        start = 1'b0;
        chk("b2b_load", word_ready, 1);
        sb.push_back('{1'b1, EMP_DG});
        send_block(emp_b, 1'b0, t);
        wait_digest(t, 0, 1'b0);

        chk("sb_drained", 256'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha256_block_ctrl.md
SHA256_BLOCK_CTRL -- requirements
Module: sha256_block_ctrl

Interface
REQ-001 Parameters: none; round count 64 and word width 32 are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a block; sampled only in IDLE.
REQ-005 first_block  input  1  sampled with start; 1 = chain from SHA-256 IV, 0 = chain from current digest.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 word_valid  input  1  message word offered.
REQ-008 word_ready  output  1  high only in LOAD.
REQ-009 word_data  input  32  message word, big-endian order: W0 first.
REQ-010 digest_valid  output  1  high only in DONE.
REQ-011 digest_ready  input  1  consumer accepts digest.
REQ-012 digest  output  256  H0..H7; H0 in bits [255:224].

Function
REQ-013 FSM states: IDLE, LOAD, ROUND, FINAL, DONE.
REQ-014 IDLE -> LOAD on start; if first_block, chaining H0..H7 load IV (6a09e667 ... 5be0cd19); otherwise H is unchanged.
REQ-015 LOAD: on entry, working regs a..h are copied from H; word counter is cleared.
REQ-016 LOAD: each word_valid & word_ready cycle shifts word_data into a 16-entry schedule window; no handshake means no shift, and stalls of any length are legal.
REQ-017 LOAD -> ROUND on the 16th handshake; the round counter is cleared to 0.
REQ-018 ROUND: one round per cycle using K[t] and W[t]; t = 0..63.
REQ-019 W[t], t<16: window head. For t>=16: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
REQ-020 sigma0 = ror7 ^ ror18 ^ shr3; sigma1 = ror17 ^ ror19 ^ shr10.
REQ-021 The window shifts by one word each round.
REQ-022 ROUND -> FINAL after round 63, when the counter wraps 63 -> 0.
REQ-023 FINAL: Hi <= Hi + working reg i, mod 2^32; one cycle; then go to DONE.
REQ-024 DONE: digest = H, held stable; digest_valid & digest_ready -> IDLE.
REQ-025 Latency: if the 16th word handshake is at cycle T, digest_valid is first high at cycle T+66.
REQ-026 start outside IDLE is ignored. start asserted in DONE in the same cycle as the digest handshake is ignored.
REQ-027 word_valid outside LOAD is ignored and consumes no data.
REQ-028 digest holds H in all states; the value is only guaranteed meaningful in DONE and IDLE.
REQ-029 All additions are modulo 2^32; carries are discarded.

Reset
REQ-030 rst forces IDLE; busy=0, word_ready=0, digest_valid=0; H0..H7 = IV; a..h, window and counters = 0.
REQ-031 rst mid-operation, in any state, aborts the block with no partial output; the next start must be honoured normally.
REQ-032 rst has priority over all handshakes in the same cycle.

Structure
REQ-033 Shared package sha256_pkg holds: the K[0..63] constant table, the IV constants, the FSM state enum, the ROUNDS=64 constant, and the sigma0/sigma1 functions.
REQ-034 One sub-module: sha256_round, the combinational single-round datapath (a..h, k, w in; a..h out), instantiated once and fed from the working registers.
REQ-035 The controller owns all registers; sha256_round holds no state.

Verification
REQ-036 Message "abc", single padded block, first_block=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, at T+66.
REQ-037 Empty message, padded block W0=80000000 and others 0 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-038 Two-block "abcdbcdecdef...nopq" message, second block with first_block=0 -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-039 "abc" with random word_valid gaps and digest_ready held low 10 cycles -> same digest, held stable; start pulses during ROUND/DONE are ignored.
REQ-040 rst asserted at round 30, then "abc" with first_block=1 -> correct "abc" digest; outputs 0 the cycle after rst.
REQ-041 Back-to-back blocks: start asserted the cycle after the DONE handshake -> LOAD entered with word_ready=1; start in the handshake cycle itself produces no LOAD.
